// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel switch debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO    = 2'd0,
        WAIT_HI = 2'd1,
        ONE     = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    localparam int DEFAULT_DB_CYCLES = 2_000_000;
    localparam int GLITCH_W          = 8;

    // Debounced level shown while in a state; early windows show the new level immediately.
    function automatic logic db_level(input db_state_t st, input logic early);
        case (st)
            ONE:     return 1'b1;
            WAIT_HI: return early;
            WAIT_LO: return ~early;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: 2-FF synchroniser, window FSM, timer and edge ticks.
// Optional glitch counter is built when DB_GLITCH_CNT_EN is defined.
//
// state   | meaning
// ZERO    | settled low, waiting for sin=1
// WAIT_HI | rising window running (early: output already high)
// ONE     | settled high, waiting for sin=0
// WAIT_LO | falling window running (early: output already low)
module db_channel
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic                in,
`ifdef DB_GLITCH_CNT_EN
    input  logic                glitch_clr,
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic                db_out,
    output logic                rise_tick,
    output logic                fall_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             sin;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ch_mode_q, ch_mode_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             win_done;

    assign sin      = s2_q;
    assign win_done = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= ZERO;
            cnt_q     <= '0;
            ch_mode_q <= 1'b0;
            db_q      <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            s1_q      <= in;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_mode_q <= ch_mode_d;
            db_q      <= db_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    // In delayed mode an opposite level aborts the window, even on its last cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_mode_d = ch_mode_q;
        case (state_q)
            ZERO: begin
                if (sin) begin
                    state_d   = WAIT_HI;
                    cnt_d     = '0;
                    ch_mode_d = mode;
                end
            end
            ONE: begin
                if (!sin) begin
                    state_d   = WAIT_LO;
                    cnt_d     = '0;
                    ch_mode_d = mode;
                end
            end
            WAIT_HI: begin
                if (!ch_mode_q && !sin) begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end else if (win_done) begin
                    state_d = ONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!ch_mode_q && sin) begin
                    state_d = ONE;
                    cnt_d   = '0;
                end else if (win_done) begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        db_d   = db_level(state_d, ch_mode_d);
        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;
    end

    assign db_out    = db_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;

`ifdef DB_GLITCH_CNT_EN
    logic                sin_prev_q;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                in_window;

    assign in_window = (state_q == WAIT_HI) || (state_q == WAIT_LO);

    // Clear has priority over a same-cycle increment; the count saturates.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (in_window && (sin != sin_prev_q) && (glitch_q != '1)) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sin_prev_q <= 1'b0;
            glitch_q   <= '0;
        end else begin
            sin_prev_q <= sin;
            glitch_q   <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: rtl/multi_ch_debounce.sv
// N-channel debouncer with runtime early/delayed mode; one db_channel per input.
// Defining DB_GLITCH_CNT_EN adds glitch_clr and the per-channel glitch_cnt bus.
module multi_ch_debounce
    import debounce_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic [N_CH-1:0]          in,
`ifdef DB_GLITCH_CNT_EN
    input  logic                     glitch_clr,
    output logic [N_CH*GLITCH_W-1:0] glitch_cnt,
`endif
    output logic [N_CH-1:0]          db_out,
    output logic [N_CH-1:0]          rise_tick,
    output logic [N_CH-1:0]          fall_tick
);

    localparam int CNT_W = $clog2(DB_CYCLES);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_channel #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .mode       (mode),
            .in         (in[i]),
`ifdef DB_GLITCH_CNT_EN
            .glitch_clr (glitch_clr),
            .glitch_cnt (glitch_cnt[GLITCH_W*i +: GLITCH_W]),
`endif
            .db_out     (db_out[i]),
            .rise_tick  (rise_tick[i]),
            .fall_tick  (fall_tick[i])
        );
    end

endmodule

// File: tb/tb_multi_ch_debounce.sv
// Self-checking bench for multi_ch_debounce (DB_CYCLES=8, N_CH=4) against a window-based reference model.
module tb_multi_ch_debounce;

    localparam int N  = 4;
    localparam int DB = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mode_r = 1'b0;
    logic [N-1:0] in_r = '0;
    logic [N-1:0] db_out, rise_tick, fall_tick;
`ifdef DB_GLITCH_CNT_EN
    logic         glitch_clr = 1'b0;
    logic [N*8-1:0] glitch_cnt;
`endif

    multi_ch_debounce #(.N_CH(N), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode_r),
        .in         (in_r),
`ifdef DB_GLITCH_CNT_EN
        .glitch_clr (glitch_clr),
        .glitch_cnt (glitch_cnt),
`endif
        .db_out     (db_out),
        .rise_tick  (rise_tick),
        .fall_tick  (fall_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: a channel has a settled level and possibly an open window.
    bit   m_s0[N], m_s1[N], m_lvl[N], m_busy[N], m_early[N], m_gprev[N];
    int   m_el[N], m_gcnt[N];
    logic [N-1:0]   exp_db, exp_rise, exp_fall;
    logic [N*8-1:0] exp_gcnt;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_s0[c] = 0; m_s1[c] = 0; m_lvl[c] = 0; m_busy[c] = 0;
            m_early[c] = 0; m_gprev[c] = 0; m_el[c] = 0; m_gcnt[c] = 0;
        end
        exp_db = '0; exp_rise = '0; exp_fall = '0; exp_gcnt = '0;
    endtask

    // Drive one cycle of inputs, advance the model over the edge, sample 1 time unit later.
    task automatic step(input logic [N-1:0] iv, input logic mv, input logic cv);
        in_r   = iv;
        mode_r = mv;
`ifdef DB_GLITCH_CNT_EN
        glitch_clr = cv;
`endif
        @(posedge clk);
        for (int c = 0; c < N; c++) begin
            bit sin;
            bit new_db;
            sin = m_s1[c];
            if (m_busy[c] && sin != m_gprev[c] && m_gcnt[c] < 255) m_gcnt[c]++;
            if (cv) m_gcnt[c] = 0;
            m_gprev[c] = sin;
            if (!m_busy[c]) begin
                if (sin != m_lvl[c]) begin
                    m_busy[c] = 1; m_el[c] = 0; m_early[c] = mv;
                end
            end else if (!m_early[c] && sin == m_lvl[c]) begin
                m_busy[c] = 0;
            end else if (m_el[c] == DB - 1) begin
                m_busy[c] = 0; m_lvl[c] = !m_lvl[c];
            end else begin
                m_el[c]++;
            end
            new_db = m_busy[c] ? (m_early[c] ? !m_lvl[c] : m_lvl[c]) : m_lvl[c];
            exp_rise[c] = new_db & !exp_db[c];
            exp_fall[c] = !new_db & exp_db[c];
            exp_db[c]   = new_db;
            exp_gcnt[8*c +: 8] = 8'(m_gcnt[c]);
            m_s1[c] = m_s0[c];
            m_s0[c] = iv[c];
        end
        #1;
    endtask

    task automatic settle(input logic mv);
        for (int k = 0; k < 30; k++) step('0, mv, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (db_out !== '0 || rise_tick !== '0 || fall_tick !== '0) begin
            errors++;
            $display("FAIL reset_state: db/rise/fall=%b/%b/%b expected 0/0/0", db_out, rise_tick, fall_tick);
        end
`ifdef DB_GLITCH_CNT_EN
        checks++;
        if (glitch_cnt !== '0) begin
            errors++;
            $display("FAIL reset_glitch: got %h expected 0", glitch_cnt);
        end
`endif
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_early_clean();
        int rise_at = -1, fall_at = -1, nrise = 0, nfall = 0;
        for (int j = 0; j < 40; j++) begin
            step((j < 20) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
            checks++;
            if (db_out !== exp_db || rise_tick !== exp_rise || fall_tick !== exp_fall) begin
                errors++;
                $display("FAIL early_clean cyc %0d: db/rise/fall=%b/%b/%b expected %b/%b/%b",
                         j, db_out, rise_tick, fall_tick, exp_db, exp_rise, exp_fall);
            end
            if (rise_tick[0]) begin nrise++; if (rise_at < 0) rise_at = j + 1; end
            if (fall_tick[0]) begin nfall++; if (fall_at < 0) fall_at = j + 1 - 20; end
        end
        checks++;
        if (rise_at != 3 || fall_at != 3 || nrise != 1 || nfall != 1) begin
            errors++;
            $display("FAIL early_clean_timing: rise_at=%0d fall_at=%0d nrise=%0d nfall=%0d expected 3/3/1/1",
                     rise_at, fall_at, nrise, nfall);
        end
        settle(1'b1);
    endtask

    task automatic test_early_bounce();
        int nrise = 0, nfall = 0, drops = 0;
        bit seen_hi = 0;
        for (int j = 0; j < 20; j++) begin
            step((j == 2 || j == 3) ? 4'b0000 : 4'b0010, 1'b1, 1'b0);
            checks++;
            if (db_out !== exp_db || rise_tick !== exp_rise || fall_tick !== exp_fall) begin
                errors++;
                $display("FAIL early_bounce cyc %0d: db/rise/fall=%b/%b/%b expected %b/%b/%b",
                         j, db_out, rise_tick, fall_tick, exp_db, exp_rise, exp_fall);
            end
            if (rise_tick[1]) nrise++;
            if (fall_tick[1]) nfall++;
            if (db_out[1]) seen_hi = 1;
            else if (seen_hi) drops++;
        end
        checks++;
        if (nrise != 1 || nfall != 0 || drops != 0 || !seen_hi) begin
            errors++;
            $display("FAIL early_bounce_summary: nrise=%0d nfall=%0d drops=%0d hi=%0d expected 1/0/0/1",
                     nrise, nfall, drops, seen_hi);
        end
        settle(1'b1);
    endtask

    task automatic test_delayed();
        int rise_at = -1, fall_at = -1, ticks = 0;
        for (int j = 0; j < 20; j++) begin
            step((j < 5) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
            checks++;
            if (db_out !== exp_db || rise_tick !== exp_rise || fall_tick !== exp_fall) begin
                errors++;
                $display("FAIL delayed_short cyc %0d: db/rise/fall=%b/%b/%b expected %b/%b/%b",
                         j, db_out, rise_tick, fall_tick, exp_db, exp_rise, exp_fall);
            end
            if (db_out[2] || rise_tick[2] || fall_tick[2]) ticks++;
        end
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL delayed_abort: active cycles=%0d expected 0", ticks);
        end
        for (int j = 0; j < 35; j++) begin
            step((j < 15) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
            checks++;
            if (db_out !== exp_db || rise_tick !== exp_rise || fall_tick !== exp_fall) begin
                errors++;
                $display("FAIL delayed_long cyc %0d: db/rise/fall=%b/%b/%b expected %b/%b/%b",
                         j, db_out, rise_tick, fall_tick, exp_db, exp_rise, exp_fall);
            end
            if (rise_tick[2] && rise_at < 0) rise_at = j + 1;
            if (fall_tick[2] && fall_at < 0) fall_at = j + 1 - 15;
        end
        checks++;
        if (rise_at != 3 + DB || fall_at != 3 + DB) begin
            errors++;
            $display("FAIL delayed_timing: rise_at=%0d fall_at=%0d expected %0d/%0d",
                     rise_at, fall_at, 3 + DB, 3 + DB);
        end
        settle(1'b0);
    endtask

    task automatic test_simultaneous();
        int rise_at = -1, fall_at = -1;
        for (int j = 0; j < 45; j++) begin
            step((j < 20) ? 4'b1111 : 4'b0000, (j < 4) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if (db_out !== exp_db || rise_tick !== exp_rise || fall_tick !== exp_fall) begin
                errors++;
                $display("FAIL simultaneous cyc %0d: db/rise/fall=%b/%b/%b expected %b/%b/%b",
                         j, db_out, rise_tick, fall_tick, exp_db, exp_rise, exp_fall);
            end
            if (rise_tick == 4'b1111 && rise_at < 0) rise_at = j + 1;
            if (fall_tick == 4'b1111 && fall_at < 0) fall_at = j + 1 - 20;
        end
        checks++;
        if (rise_at != 3 || fall_at != 3 + DB) begin
            errors++;
            $display("FAIL simultaneous_timing: rise_at=%0d fall_at=%0d expected 3/%0d",
                     rise_at, fall_at, 3 + DB);
        end
        settle(1'b0);
    endtask

    task automatic test_reset_mid();
        int rise_at = -1;
        for (int j = 0; j < 5; j++) step(4'b0001, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (db_out !== '0 || rise_tick !== '0 || fall_tick !== '0) begin
            errors++;
            $display("FAIL reset_mid: db/rise/fall=%b/%b/%b expected 0/0/0", db_out, rise_tick, fall_tick);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int j = 0; j < 15; j++) begin
            step(4'b0001, 1'b1, 1'b0);
            checks++;
            if (db_out !== exp_db || rise_tick !== exp_rise || fall_tick !== exp_fall) begin
                errors++;
                $display("FAIL reset_release cyc %0d: db/rise/fall=%b/%b/%b expected %b/%b/%b",
                         j, db_out, rise_tick, fall_tick, exp_db, exp_rise, exp_fall);
            end
            if (rise_tick[0] && rise_at < 0) rise_at = j + 1;
        end
        checks++;
        if (rise_at != 3) begin
            errors++;
            $display("FAIL reset_release_timing: rise_at=%0d expected 3", rise_at);
        end
        settle(1'b1);
    endtask

    task automatic test_random();
        logic [N-1:0] lv = '0;
        int           hold[N];
        logic         mv = 1'b1;
        for (int c = 0; c < N; c++) hold[c] = 1;
        for (int j = 0; j < 3000; j++) begin
            for (int c = 0; c < N; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    lv[c] = ~lv[c];
                    hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(DB - 2, 3 * DB));
                end
            end
            if ($urandom_range(0, 60) == 0) mv = ~mv;
            step(lv, mv, $urandom_range(0, 150) == 0);
            checks++;
            if (db_out !== exp_db || rise_tick !== exp_rise || fall_tick !== exp_fall) begin
                errors++;
                $display("FAIL random cyc %0d: db/rise/fall=%b/%b/%b expected %b/%b/%b",
                         j, db_out, rise_tick, fall_tick, exp_db, exp_rise, exp_fall);
            end
`ifdef DB_GLITCH_CNT_EN
            checks++;
            if (glitch_cnt !== exp_gcnt) begin
                errors++;
                $display("FAIL random_glitch cyc %0d: got %h expected %h", j, glitch_cnt, exp_gcnt);
            end
`endif
        end
        settle(1'b1);
    endtask

`ifdef DB_GLITCH_CNT_EN
    task automatic test_glitch();
        logic [N-1:0] pat;
        logic [N-1:0] t = '0;
        step('0, 1'b1, 1'b1);
        settle(1'b1);
        for (int j = 0; j < 25; j++) begin
            pat = (j == 0 || j == 1 || j == 3) ? 4'b0001 : 4'b0000;
            step(pat, 1'b1, 1'b0);
            checks++;
            if (glitch_cnt !== exp_gcnt || db_out !== exp_db) begin
                errors++;
                $display("FAIL glitch_three cyc %0d: cnt=%h db=%b expected %h %b",
                         j, glitch_cnt, db_out, exp_gcnt, exp_db);
            end
        end
        checks++;
        if (glitch_cnt[7:0] !== 8'd3) begin
            errors++;
            $display("FAIL glitch_three_value: got %0d expected 3", glitch_cnt[7:0]);
        end
        for (int j = 0; j < 400; j++) begin
            t = ~t;
            step(t & 4'b0001, 1'b1, 1'b0);
            checks++;
            if (glitch_cnt !== exp_gcnt) begin
                errors++;
                $display("FAIL glitch_toggle cyc %0d: got %h expected %h", j, glitch_cnt, exp_gcnt);
            end
        end
        checks++;
        if (glitch_cnt[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL glitch_saturate: got %h expected ff", glitch_cnt[7:0]);
        end
        t = ~t;
        step(t & 4'b0001, 1'b1, 1'b1);
        checks++;
        if (glitch_cnt[7:0] !== 8'h00 || glitch_cnt !== exp_gcnt) begin
            errors++;
            $display("FAIL glitch_clear: got %h expected 00 (model %h)", glitch_cnt[7:0], exp_gcnt);
        end
        settle(1'b1);
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_early_clean();
        test_early_bounce();
        test_delayed();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef DB_GLITCH_CNT_EN
        test_glitch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
